// File: rtl/ipml_fifo_v2_0_pkg.sv
// Sizing helpers and configuration checks shared by the ipml_fifo_v2_0 family.
package ipml_fifo_v2_0_pkg;

    localparam int unsigned MaxRatio      = 16;
    localparam int unsigned MinDepthWidth = 4;
    localparam int unsigned MaxDepthWidth = 16;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned min_width(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // Level width for one side: storage depth in that side's words plus head and sign headroom.
    function automatic int unsigned level_width(input int unsigned side, input int unsigned other,
                                                input int unsigned dw);
        return dw + clog2(max_width(side, other) / side) + 2;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned w, input int unsigned r,
                                              input int unsigned dw);
        return dw + clog2(max_width(w, r) / min_width(w, r)) + 2;
    endfunction

    function automatic bit cfg_legal(input int unsigned w, input int unsigned r,
                                     input int unsigned dw);
        int unsigned mx;
        int unsigned mn;
        mx = max_width(w, r);
        mn = min_width(w, r);
        if (mn == 0) return 1'b0;
        if ((mx % mn) != 0) return 1'b0;
        if (!is_pow2(mx / mn) || (mx / mn) > MaxRatio) return 1'b0;
        return (dw >= MinDepthWidth) && (dw <= MaxDepthWidth);
    endfunction

endpackage

// File: rtl/ipml_fifo_v2_0_sdpram.sv
// Inferred simple dual-port RAM: one clock, registered read port, no reset on the array.
module ipml_fifo_v2_0_sdpram #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ipml_fifo_v2_0_sync_mix_fifo.sv
// Single-clock FIFO with power-of-two write/read width conversion and exact water levels.
// Define IPML_FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read.
module ipml_fifo_v2_0_sync_mix_fifo
    import ipml_fifo_v2_0_pkg::*;
#(
    parameter int unsigned c_WR_DATA_WIDTH   = 32,
    parameter int unsigned c_RD_DATA_WIDTH   = 8,
    parameter int unsigned c_DEPTH_WIDTH     = 9,
    parameter int unsigned c_ALMOST_FULL_NUM = 500,
    parameter int unsigned c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [c_WR_DATA_WIDTH-1:0] wr_data,
    input  logic                       wr_en,
    output logic                       wr_full,
    output logic                       almost_full,
    output logic [level_width(c_WR_DATA_WIDTH, c_RD_DATA_WIDTH, c_DEPTH_WIDTH)-1:0]
                                       wr_water_level,
    output logic                       wr_overflow,
    output logic [c_RD_DATA_WIDTH-1:0] rd_data,
    input  logic                       rd_en,
    output logic                       rd_empty,
    output logic                       almost_empty,
    output logic [level_width(c_RD_DATA_WIDTH, c_WR_DATA_WIDTH, c_DEPTH_WIDTH)-1:0]
                                       rd_water_level,
    output logic                       rd_underflow
);

    localparam int unsigned WrW         = c_WR_DATA_WIDTH;
    localparam int unsigned RdW         = c_RD_DATA_WIDTH;
    localparam int unsigned Dw          = c_DEPTH_WIDTH;
    localparam int unsigned Mw          = max_width(WrW, RdW);
    localparam int unsigned Uw          = min_width(WrW, RdW);
    localparam int unsigned PackRatio   = Mw / WrW;
    localparam int unsigned UnpackRatio = Mw / RdW;
    localparam int unsigned CntW        = cnt_width(WrW, RdW, Dw);
    localparam int unsigned WrShift     = clog2(WrW / Uw);
    localparam int unsigned RdShift     = clog2(RdW / Uw);
    localparam int unsigned IdxW        = (UnpackRatio > 1) ? clog2(UnpackRatio) : 1;
    localparam int unsigned PackIdxW    = (PackRatio > 1) ? clog2(PackRatio) : 1;
    localparam logic [Dw:0] PtrOne      = (Dw+1)'(1);

    if (!cfg_legal(WrW, RdW, Dw)) begin : g_bad_cfg
        $error("ipml_fifo_v2_0_sync_mix_fifo: illegal width ratio or depth width");
    end

    logic [Dw:0]     wptr_q, fptr_q, rptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q;
    logic            head_valid_q;
    logic [Mw-1:0]   head_q;
    logic [IdxW-1:0] head_idx_q;
    logic [RdW-1:0]  head_slice;
    logic [Mw-1:0]   ram_wdata, ram_rdata;
    logic            ram_we, pk_last;
    logic            ram_full, ram_avail;
    logic            wr_acc, pop, last_pop, take, fetch;
    logic            wr_overflow_q, rd_underflow_q;

    // rptr advances only when a word leaves RAM's output register, so the staged word still
    // counts against capacity.
    assign ram_full  = (wptr_q[Dw] != rptr_q[Dw]) && (wptr_q[Dw-1:0] == rptr_q[Dw-1:0]);
    assign ram_avail = (wptr_q != fptr_q);

    assign wr_full  = ram_full && pk_last;
    assign rd_empty = !head_valid_q;
    assign wr_acc   = wr_en && !wr_full;
    assign pop      = rd_en && head_valid_q;
    assign last_pop = pop && (head_idx_q == IdxW'(UnpackRatio - 1));
    assign take     = pend_q && (!head_valid_q || last_pop);
    assign fetch    = ram_avail && (!pend_q || take);

    if (PackRatio > 1) begin : g_pack
        logic [PackIdxW-1:0] pk_cnt_q;
        logic [Mw-WrW-1:0]   pk_q;

        assign pk_last   = (pk_cnt_q == PackIdxW'(PackRatio - 1));
        assign ram_we    = wr_acc && pk_last;
        assign ram_wdata = {wr_data, pk_q};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pk_cnt_q <= '0;
                pk_q     <= '0;
            end else if (wr_acc) begin
                if (!pk_last) pk_q[pk_cnt_q*WrW +: WrW] <= wr_data;
                pk_cnt_q <= pk_last ? '0 : pk_cnt_q + PackIdxW'(1);
            end
        end
    end else begin : g_nopack
        assign pk_last   = 1'b1;
        assign ram_we    = wr_acc;
        assign ram_wdata = wr_data;
    end

    ipml_fifo_v2_0_sdpram #(
        .ADDR_WIDTH (Dw),
        .DATA_WIDTH (Mw)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wptr_q[Dw-1:0]),
        .wr_data (ram_wdata),
        .rd_en   (fetch),
        .rd_addr (fptr_q[Dw-1:0]),
        .rd_data (ram_rdata)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc) cnt_d = cnt_d + CntW'(WrW / Uw);
        if (pop)    cnt_d = cnt_d - CntW'(RdW / Uw);
    end

    // pend_q marks a fetched word waiting in the RAM output register; the head takes it on
    // the same edge its last slice pops, so a continuous read stream has no bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q         <= '0;
            fptr_q         <= '0;
            rptr_q         <= '0;
            cnt_q          <= '0;
            pend_q         <= 1'b0;
            head_valid_q   <= 1'b0;
            head_q         <= '0;
            head_idx_q     <= '0;
            wr_overflow_q  <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            if (ram_we) wptr_q <= wptr_q + PtrOne;
            if (fetch)  fptr_q <= fptr_q + PtrOne;
            cnt_q          <= cnt_d;
            wr_overflow_q  <= wr_en && wr_full;
            rd_underflow_q <= rd_en && rd_empty;

            if (fetch)     pend_q <= 1'b1;
            else if (take) pend_q <= 1'b0;

            if (take) begin
                head_q       <= ram_rdata;
                head_idx_q   <= '0;
                head_valid_q <= 1'b1;
                rptr_q       <= rptr_q + PtrOne;
            end else if (last_pop) begin
                head_valid_q <= 1'b0;
                head_idx_q   <= '0;
            end else if (pop) begin
                head_idx_q <= head_idx_q + IdxW'(1);
            end
        end
    end

    if (UnpackRatio > 1) begin : g_unpack
        assign head_slice = head_q[head_idx_q*RdW +: RdW];
    end else begin : g_nounpack
        assign head_slice = head_q;
    end

`ifdef IPML_FIFO_FWFT_EN
    assign rd_data = head_valid_q ? head_slice : '0;
`else
    logic [RdW-1:0] rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rd_data_q <= '0;
        else if (pop) rd_data_q <= head_slice;
    end

    assign rd_data = rd_data_q;
`endif

    assign wr_water_level = cnt_q[CntW-1:WrShift];
    assign rd_water_level = cnt_q[CntW-1:RdShift];
    assign almost_full    = 32'(wr_water_level) >= c_ALMOST_FULL_NUM;
    assign almost_empty   = 32'(rd_water_level) <= c_ALMOST_EMPTY_NUM;
    assign wr_overflow    = wr_overflow_q;
    assign rd_underflow   = rd_underflow_q;

endmodule

// File: tb/tb_ipml_fifo_v2_0_sync_mix_fifo.sv
// Directed bench: a 32->8 FIFO (dut_a) and an 8->32 FIFO (dut_b), depth 16 words each.
module tb_ipml_fifo_v2_0_sync_mix_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_wr_data = '0;
    logic        a_wr_en = 1'b0, a_rd_en = 1'b0;
    logic        a_wr_full, a_almost_full, a_wr_overflow;
    logic        a_rd_empty, a_almost_empty, a_rd_underflow;
    logic [5:0]  a_wr_lvl;
    logic [7:0]  a_rd_lvl;
    logic [7:0]  a_rd_data;

    logic [7:0]  b_wr_data = '0;
    logic        b_wr_en = 1'b0, b_rd_en = 1'b0;
    logic        b_wr_full, b_almost_full, b_wr_overflow;
    logic        b_rd_empty, b_almost_empty, b_rd_underflow;
    logic [7:0]  b_wr_lvl;
    logic [5:0]  b_rd_lvl;
    logic [31:0] b_rd_data;

    int          total = 0;
    int          bad = 0;
    int          exp_rd_lvl = 0;
    logic [7:0]  q[$];

    always #5 clk = ~clk;

    ipml_fifo_v2_0_sync_mix_fifo #(
        .c_WR_DATA_WIDTH    (32),
        .c_RD_DATA_WIDTH    (8),
        .c_DEPTH_WIDTH      (4),
        .c_ALMOST_FULL_NUM  (16),
        .c_ALMOST_EMPTY_NUM (4)
    ) dut_a (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (a_wr_data),
        .wr_en          (a_wr_en),
        .wr_full        (a_wr_full),
        .almost_full    (a_almost_full),
        .wr_water_level (a_wr_lvl),
        .wr_overflow    (a_wr_overflow),
        .rd_data        (a_rd_data),
        .rd_en          (a_rd_en),
        .rd_empty       (a_rd_empty),
        .almost_empty   (a_almost_empty),
        .rd_water_level (a_rd_lvl),
        .rd_underflow   (a_rd_underflow)
    );

    ipml_fifo_v2_0_sync_mix_fifo #(
        .c_WR_DATA_WIDTH    (8),
        .c_RD_DATA_WIDTH    (32),
        .c_DEPTH_WIDTH      (4),
        .c_ALMOST_FULL_NUM  (12),
        .c_ALMOST_EMPTY_NUM (0)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (b_wr_data),
        .wr_en          (b_wr_en),
        .wr_full        (b_wr_full),
        .almost_full    (b_almost_full),
        .wr_water_level (b_wr_lvl),
        .wr_overflow    (b_wr_overflow),
        .rd_data        (b_rd_data),
        .rd_en          (b_rd_en),
        .rd_empty       (b_rd_empty),
        .almost_empty   (b_almost_empty),
        .rd_water_level (b_rd_lvl),
        .rd_underflow   (b_rd_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) q.push_back(w[k*8 +: 8]);
    endtask

    // One read on dut_a, optionally with a concurrent write; checks data and read level.
    task automatic read_cycle(input string tag, input bit do_wr, input logic [31:0] wd);
        logic [7:0] e;
        e = (q.size() > 0) ? q.pop_front() : 8'h00;
        a_rd_en   = 1'b1;
        a_wr_en   = do_wr;
        a_wr_data = wd;
`ifdef IPML_FIFO_FWFT_EN
        chk(tag, 32'(a_rd_data), 32'(e));
        tick();
`else
        tick();
        chk(tag, 32'(a_rd_data), 32'(e));
`endif
        if (do_wr) begin
            push_word(wd);
            exp_rd_lvl += 4;
        end
        exp_rd_lvl -= 1;
        chk({tag, "_lvl"}, 32'(a_rd_lvl), 32'(exp_rd_lvl));
        a_rd_en = 1'b0;
        a_wr_en = 1'b0;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_wr_full"}, 32'(a_wr_full), 0);
        chk({tag, "_almost_full"}, 32'(a_almost_full), 0);
        chk({tag, "_rd_empty"}, 32'(a_rd_empty), 1);
        chk({tag, "_almost_empty"}, 32'(a_almost_empty), 1);
        chk({tag, "_wr_lvl"}, 32'(a_wr_lvl), 0);
        chk({tag, "_rd_lvl"}, 32'(a_rd_lvl), 0);
        chk({tag, "_ovf"}, 32'(a_wr_overflow), 0);
        chk({tag, "_udf"}, 32'(a_rd_underflow), 0);
        chk({tag, "_rd_data"}, 32'(a_rd_data), 0);
    endtask

    initial begin
        logic [7:0]  b8;
        logic [31:0] wd;

        tick();
        tick();
        chk_a_reset("rst");
        chk("rst_b_rd_empty", 32'(b_rd_empty), 1);
        chk("rst_b_rd_data", b_rd_data, 0);
        rst = 1'b0;
        tick();

        // Single word, then four byte reads LSB first.
        a_wr_en = 1'b1;
        a_wr_data = 32'h44332211;
        tick();
        a_wr_en = 1'b0;
        push_word(32'h44332211);
        exp_rd_lvl = 4;
        chk("lat_e0_empty", 32'(a_rd_empty), 1);
        chk("lat_e0_rd_lvl", 32'(a_rd_lvl), 4);
        chk("lat_e0_wr_lvl", 32'(a_wr_lvl), 1);
        tick();
        chk("lat_e1_empty", 32'(a_rd_empty), 1);
        tick();
        chk("lat_e2_empty", 32'(a_rd_empty), 0);
        for (int i = 0; i < 4; i++) read_cycle("byte_rd", 1'b0, '0);
        chk("drain_empty", 32'(a_rd_empty), 1);
        chk("drain_wr_lvl", 32'(a_wr_lvl), 0);
        chk("drain_almost_empty", 32'(a_almost_empty), 1);
`ifdef IPML_FIFO_FWFT_EN
        chk("drain_rd_data", 32'(a_rd_data), 0);
`else
        chk("drain_rd_data", 32'(a_rd_data), 32'h44);
`endif

        // Underflow: refused read changes nothing but the pulse.
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        chk("udf_pulse", 32'(a_rd_underflow), 1);
        chk("udf_rd_lvl", 32'(a_rd_lvl), 0);
        chk("udf_wr_lvl", 32'(a_wr_lvl), 0);
`ifdef IPML_FIFO_FWFT_EN
        chk("udf_rd_data", 32'(a_rd_data), 0);
`else
        chk("udf_rd_data", 32'(a_rd_data), 32'h44);
`endif
        tick();
        chk("udf_pulse_end", 32'(a_rd_underflow), 0);

        // Fill: 17 accepted (16 RAM + head), 18th overflows.
        for (int i = 0; i < 18; i++) begin
            b8 = 8'(i);
            wd = {b8, b8 ^ 8'h55, b8 ^ 8'hAA, ~b8};
            a_wr_en = 1'b1;
            a_wr_data = wd;
            tick();
            if (i < 17) begin
                push_word(wd);
                exp_rd_lvl += 4;
            end
            chk("fill_wr_lvl", 32'(a_wr_lvl), (i < 17) ? 32'(i + 1) : 32'd17);
            chk("fill_full", 32'(a_wr_full), (i >= 16) ? 32'd1 : 32'd0);
            chk("fill_almost_full", 32'(a_almost_full), (i >= 15) ? 32'd1 : 32'd0);
            chk("fill_ovf", 32'(a_wr_overflow), (i == 17) ? 32'd1 : 32'd0);
        end
        a_wr_en = 1'b0;
        tick();
        chk("ovf_pulse_end", 32'(a_wr_overflow), 0);
        chk("full_wr_lvl", 32'(a_wr_lvl), 17);
        chk("full_rd_lvl", 32'(a_rd_lvl), 68);

        // Drain to 32 read words with back-to-back reads.
        for (int i = 0; i < 36; i++) begin
            read_cycle("drain36", 1'b0, '0);
            chk("drain36_no_bubble", 32'(a_rd_empty), 0);
        end
        chk("lvl32_wr_lvl", 32'(a_wr_lvl), 8);

        // Continuous read stream with a write every fourth cycle.
        for (int i = 0; i < 20; i++) begin
            b8 = 8'(8'h80 + i);
            wd = {b8, ~b8, b8 ^ 8'h0F, b8 ^ 8'hF0};
            read_cycle("stream", (i % 4) == 0, wd);
            chk("stream_no_bubble", 32'(a_rd_empty), 0);
            chk("stream_ovf", 32'(a_wr_overflow), 0);
            chk("stream_udf", 32'(a_rd_underflow), 0);
        end
        chk("stream_end_lvl", 32'(a_rd_lvl), 32);

        // Down to level 9, then asynchronous reset mid-stream.
        for (int i = 0; i < 23; i++) read_cycle("to9", 1'b0, '0);
        chk("lvl9", 32'(a_rd_lvl), 9);
        rst = 1'b1;
        #1;
        chk_a_reset("async_rst");
        tick();
        rst = 1'b0;
        q.delete();
        exp_rd_lvl = 0;
        tick();
        a_wr_en = 1'b1;
        a_wr_data = 32'hDEADBEEF;
        tick();
        a_wr_en = 1'b0;
        push_word(32'hDEADBEEF);
        exp_rd_lvl = 4;
        tick();
        tick();
        chk("post_rst_ready", 32'(a_rd_empty), 0);
        for (int i = 0; i < 4; i++) read_cycle("post_rst_rd", 1'b0, '0);
        chk("post_rst_empty", 32'(a_rd_empty), 1);

        // Narrow write, wide read: packer holds partial words out of view.
        b_wr_en = 1'b1;
        b_wr_data = 8'hAA;
        tick();
        b_wr_data = 8'hBB;
        tick();
        b_wr_data = 8'hCC;
        tick();
        b_wr_en = 1'b0;
        chk("pack3_rd_lvl", 32'(b_rd_lvl), 0);
        chk("pack3_wr_lvl", 32'(b_wr_lvl), 3);
        chk("pack3_empty", 32'(b_rd_empty), 1);
        b_wr_en = 1'b1;
        b_wr_data = 8'hDD;
        tick();
        b_wr_en = 1'b0;
        chk("pack4_rd_lvl", 32'(b_rd_lvl), 1);
        chk("pack4_wr_lvl", 32'(b_wr_lvl), 4);
        tick();
        chk("pack_e1_empty", 32'(b_rd_empty), 1);
        tick();
        chk("pack_e2_empty", 32'(b_rd_empty), 0);
`ifdef IPML_FIFO_FWFT_EN
        chk("pack_rd_data", b_rd_data, 32'hDDCCBBAA);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
`else
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        chk("pack_rd_data", b_rd_data, 32'hDDCCBBAA);
`endif
        chk("pack_after_empty", 32'(b_rd_empty), 1);
        chk("pack_after_rd_lvl", 32'(b_rd_lvl), 0);
        chk("pack_after_wr_lvl", 32'(b_wr_lvl), 0);
        chk("pack_no_udf", 32'(b_rd_underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
